// File: rtl/spi_apb_xfer_seq.sv
// APB master that sequences a GRLIB spictrl: one mode write, then per word a
// transmit write, event polls, a receive read and a valid/ready hand-back.
module spi_apb_xfer_seq #(
    parameter logic [31:0] PADDR_BASE = 32'h0000_0000,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_mode,
    input  logic        cfg_valid,
    output logic        cfg_done,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [31:0] apb_paddr,
    output logic [31:0] apb_pwdata,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    input  logic        apb_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_RUN, S_WAIT_NF, S_TX, S_WAIT_NE, S_RX, S_HOLD
    } state_e;

    typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_e;

    localparam logic [15:0] POLL_LIMIT_C = 16'(POLL_LIMIT);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [15:0] poll_q, poll_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        err_q, err_d;
    logic        cfg_done_q, cfg_done_d;

    logic        xfer_done;
    logic        setup_req;
    state_e      setup_state;
    logic [15:0] poll_inc;

    function automatic logic [31:0] reg_offset(input state_e s);
        case (s)
            S_CFG:              return 32'h20;
            S_WAIT_NF, S_WAIT_NE: return 32'h24;
            S_TX:               return 32'h30;
            S_RX:               return 32'h34;
            default:            return 32'h00;
        endcase
    endfunction

    assign xfer_done = psel_q && penable_q && apb_pready;
    assign poll_inc  = poll_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_GAP;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            poll_q     <= 16'h0;
            rx_data_q  <= 32'h0;
            err_q      <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            poll_q     <= poll_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        poll_d      = poll_q;
        rx_data_d   = rx_data_q;
        err_d       = err_q;
        cfg_done_d  = 1'b0;
        setup_req   = 1'b0;
        setup_state = S_IDLE;

        // Shared APB phase sequencing; a finished transfer parks in PH_GAP so
        // the following SETUP is always preceded by one idle cycle.
        if (state_q inside {S_CFG, S_WAIT_NF, S_TX, S_WAIT_NE, S_RX}) begin
            case (phase_q)
                PH_SETUP: begin
                    penable_d = 1'b1;
                    phase_d   = PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (apb_pready) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        phase_d   = PH_GAP;
                        if (apb_pslverr) err_d = 1'b1;
                    end
                end
                default: begin
                    setup_req   = 1'b1;
                    setup_state = state_q;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    setup_req   = 1'b1;
                    setup_state = S_CFG;
                end
            end
            S_CFG: begin
                if (xfer_done) begin
                    cfg_done_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (tx_valid) begin
                    setup_req   = 1'b1;
                    setup_state = S_WAIT_NF;
                    poll_d      = 16'h0;
                end
            end
            S_WAIT_NF: begin
                if (xfer_done) begin
                    poll_d = poll_inc;
                    if (apb_prdata[8]) begin
                        state_d = S_TX;
                    end else if (poll_inc == POLL_LIMIT_C) begin
                        err_d   = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_TX: begin
                if (xfer_done) begin
                    state_d = S_WAIT_NE;
                    poll_d  = 16'h0;
                end
            end
            S_WAIT_NE: begin
                if (xfer_done) begin
                    poll_d = poll_inc;
                    if (apb_prdata[9]) begin
                        state_d = S_RX;
                    end else if (poll_inc == POLL_LIMIT_C) begin
                        err_d   = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RX: begin
                if (xfer_done) begin
                    rx_data_d = apb_prdata;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rx_ready) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (setup_req) begin
            state_d   = setup_state;
            phase_d   = PH_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = PADDR_BASE + reg_offset(setup_state);
            pwrite_d  = (setup_state == S_CFG) || (setup_state == S_TX);
            pwdata_d  = (setup_state == S_CFG) ? cfg_mode :
                        (setup_state == S_TX)  ? tx_data  : 32'h0;
        end
    end

    always_comb begin
        apb_psel    = psel_q;
        apb_penable = penable_q;
        apb_pwrite  = pwrite_q;
        apb_paddr   = paddr_q;
        apb_pwdata  = pwdata_q;
        cfg_done    = cfg_done_q;
        err         = err_q;
        rx_data     = rx_data_q;
        rx_valid    = (state_q == S_HOLD);
        // The word is consumed on the edge that ends the transmit ACCESS; a
        // reset on that edge wins, so the handshake is withheld.
        tx_ready    = (state_q == S_TX) && (phase_q == PH_ACCESS) && apb_pready && !rst;
    end

endmodule

// File: tb/tb_spi_apb_xfer_seq.sv
// Bench for spi_apb_xfer_seq: spictrl-like APB slave model, scoreboard queues
// for transmitted and received words, protocol stability monitor.
module tb_spi_apb_xfer_seq;

    localparam logic [31:0] MASK = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_mode = 32'h0;
    logic        cfg_valid = 1'b0;
    logic        cfg_done;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        err;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_paddr, apb_pwdata;
    logic [31:0] apb_prdata = 32'h0;
    logic        apb_pready = 1'b0;
    logic        apb_pslverr = 1'b0;

    always #5 clk = ~clk;

    spi_apb_xfer_seq #(.PADDR_BASE(32'h0), .POLL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_valid(cfg_valid), .cfg_done(cfg_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // slave model knobs and statistics
    int          ws = 0;
    int          ne_delay = 0;
    bit          ne_never = 1'b0;
    bit          fixed_rx = 1'b0;
    bit          slverr_rx = 1'b0;
    logic [31:0] last_tx = 32'h0;
    logic [31:0] exp_cfg = 32'h0;
    int          acc_cyc = 0;
    int          ev_since_tx = 0;
    int          ev_reads = 0;
    int          rx_reads = 0;
    int          cfg_writes = 0;
    int          tx_ready_cnt = 0;
    int          tx_sent = 0;
    int          ev_base = 0;
    logic [31:0] exp_tx[$];
    logic [31:0] exp_rx[$];

    always @(posedge clk) begin
        #1;
        if (apb_psel && apb_penable) begin
            apb_pready = (acc_cyc >= ws);
            acc_cyc++;
        end else begin
            apb_pready = 1'b0;
            acc_cyc = 0;
        end
        apb_prdata = 32'h0;
        if (apb_paddr == 32'h24)
            apb_prdata = {22'd0, (!ne_never && ev_since_tx >= ne_delay), 1'b1, 8'd0};
        else if (apb_paddr == 32'h34)
            apb_prdata = fixed_rx ? 32'h0000_ABCD : (last_tx ^ MASK);
        apb_pslverr = slverr_rx && apb_pready && !apb_pwrite && (apb_paddr == 32'h34);
    end

    logic [31:0] cap_addr = 32'h0, cap_data = 32'h0;
    logic        cap_wr = 1'b0;
    bit          prev_done = 1'b0;

    always @(negedge clk) begin
        bit done;
        done = apb_psel && apb_penable && apb_pready && !rst;
        if (prev_done) chk("idle_gap", 32'(apb_psel), 32'd0);
        if (apb_psel && !apb_penable) begin
            cap_addr = apb_paddr;
            cap_data = apb_pwdata;
            cap_wr   = apb_pwrite;
        end else if (apb_psel && apb_penable) begin
            chk("stab_addr", apb_paddr, cap_addr);
            chk("stab_data", apb_pwdata, cap_data);
            chk("stab_write", 32'(apb_pwrite), 32'(cap_wr));
        end
        if (tx_ready === 1'b1) tx_ready_cnt++;
        if (done) begin
            if (apb_pwrite && apb_paddr == 32'h20) begin
                cfg_writes++;
                chk("cfg_wdata", apb_pwdata, exp_cfg);
            end else if (apb_pwrite && apb_paddr == 32'h30) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", apb_pwdata, 32'hDEAD_BEEF);
                else chk("tx_wdata", apb_pwdata, exp_tx.pop_front());
                last_tx = apb_pwdata;
                ev_since_tx = 0;
            end else if (!apb_pwrite && apb_paddr == 32'h24) begin
                ev_reads++;
                ev_since_tx++;
            end else if (!apb_pwrite && apb_paddr == 32'h34) begin
                rx_reads++;
            end else begin
                chk("bad_access", apb_paddr, 32'hFFFF_FFFF);
            end
        end
        prev_done = done;
    end

    task automatic do_cfg(input logic [31:0] mode);
        int w0;
        w0 = cfg_writes;
        cfg_mode  = mode;
        exp_cfg   = mode;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_setup_psel", 32'(apb_psel), 32'd1);
        chk("cfg_setup_pen", 32'(apb_penable), 32'd0);
        chk("cfg_paddr", apb_paddr, 32'h20);
        chk("cfg_pwrite", 32'(apb_pwrite), 32'd1);
        chk("cfg_pwdata", apb_pwdata, mode);
        chk("cfg_done_early1", 32'(cfg_done), 32'd0);
        @(negedge clk);
        chk("cfg_access_pen", 32'(apb_penable), 32'd1);
        chk("cfg_done_early2", 32'(cfg_done), 32'd0);
        @(negedge clk);
        chk("cfg_done_pulse", 32'(cfg_done), 32'd1);
        chk("cfg_idle_psel", 32'(apb_psel), 32'd0);
        @(negedge clk);
        chk("cfg_done_single", 32'(cfg_done), 32'd0);
        chk("cfg_write_count", 32'(cfg_writes - w0), 32'd1);
    endtask

    task automatic wait_tx_ready();
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_seen", 32'(tx_ready), 32'd1);
        ev_base = ev_reads;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit want_rx, input logic [31:0] rxw);
        exp_tx.push_back(w);
        if (want_rx) exp_rx.push_back(rxw);
        tx_sent++;
        tx_data  = w;
        tx_valid = 1'b1;
        wait_tx_ready();
    endtask

    task automatic recv_word(input int hold);
        int n;
        logic [31:0] v;
        n = 0;
        while (rx_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_valid_seen", 32'(rx_valid), 32'd1);
        if (rx_valid !== 1'b1) return;
        v = rx_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rx_valid), 32'd1);
            chk("bp_data", rx_data, v);
            chk("bp_no_apb", 32'(apb_psel), 32'd0);
        end
        rx_ready = 1'b1;
        if (exp_rx.size() == 0) chk("rx_unexpected", rx_data, 32'hDEAD_BEEF);
        else chk("rx_data", rx_data, exp_rx.pop_front());
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_drop", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rx_base;
        int txr_before;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        chk("rst_psel", 32'(apb_psel), 32'd0);
        chk("rst_penable", 32'(apb_penable), 32'd0);
        chk("rst_paddr", apb_paddr, 32'h0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;

        // tx_valid in IDLE must not start any bus activity
        tx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ignores_tx", 32'(apb_psel), 32'd0);
        end
        tx_valid = 1'b0;
        @(negedge clk);

        do_cfg(32'h030B_0000);

        // single transfer against a fixed slave word
        fixed_rx = 1'b1;
        ne_delay = 2;
        rx_base  = rx_reads;
        send_word(32'h0012_3456, 1'b1, 32'h0000_ABCD);
        recv_word(0);
        chk("ne_polls", 32'(ev_reads - ev_base), 32'd3);
        chk("rx_read_count", 32'(rx_reads - rx_base), 32'd1);

        // backpressure with the next word already offered
        fixed_rx = 1'b0;
        ne_delay = 1;
        send_word(32'hCAFE_0001, 1'b1, 32'hCAFE_0001 ^ MASK);
        exp_tx.push_back(32'hCAFE_0002);
        exp_rx.push_back(32'hCAFE_0002 ^ MASK);
        tx_sent++;
        tx_data  = 32'hCAFE_0002;
        tx_valid = 1'b1;
        recv_word(20);
        wait_tx_ready();
        recv_word(0);

        // wait states on every access
        ws = 3;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            ne_delay = $urandom_range(0, 3);
            send_word(w, 1'b1, w ^ MASK);
            recv_word(0);
        end
        chk("ws_tx_ready_total", 32'(tx_ready_cnt), 32'(tx_sent));

        // NE never rises: poll limit of 4
        ws = 0;
        ne_never = 1'b1;
        send_word(32'h1357_9BDF, 1'b0, 32'h0);
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            @(negedge clk);
            chk("to_no_rx", 32'(rx_valid), 32'd0);
            n++;
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_polls", 32'(ev_reads - ev_base), 32'd4);
        repeat (5) begin
            @(negedge clk);
            chk("to_rx_valid", 32'(rx_valid), 32'd0);
            chk("to_quiet", 32'(apb_psel), 32'd0);
        end
        ne_never = 1'b0;
        send_word(32'h2468_ACE0, 1'b1, 32'h2468_ACE0 ^ MASK);
        recv_word(0);
        chk("to_err_sticky", 32'(err), 32'd1);

        // reset in the middle of a transmit ACCESS
        ws = 3;
        tx_data  = 32'h0BAD_F00D;
        tx_valid = 1'b1;
        n = 0;
        while (!(apb_psel && apb_penable && apb_pwrite && apb_paddr == 32'h30) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_tx_access_seen", apb_paddr, 32'h30);
        txr_before = tx_ready_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_psel", 32'(apb_psel), 32'd0);
        chk("abort_penable", 32'(apb_penable), 32'd0);
        chk("abort_tx_ready", 32'(tx_ready), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        tx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle", 32'(apb_psel), 32'd0);
        end
        chk("abort_no_tx_ready", 32'(tx_ready_cnt), 32'(txr_before));

        // slave error on the receive read
        ws = 0;
        do_cfg(32'h0000_0001);
        chk("slverr_pre_err", 32'(err), 32'd0);
        slverr_rx = 1'b1;
        fixed_rx  = 1'b1;
        ne_delay  = 0;
        send_word(32'h0000_55AA, 1'b1, 32'h0000_ABCD);
        recv_word(0);
        chk("slverr_err", 32'(err), 32'd1);
        slverr_rx = 1'b0;

        repeat (3) @(negedge clk);
        chk("tx_ready_total", 32'(tx_ready_cnt), 32'(tx_sent));
        chk("exp_tx_empty", 32'(exp_tx.size()), 32'd0);
        chk("exp_rx_empty", 32'(exp_rx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_apb_xfer_seq.md
# spi_apb_xfer_seq

Hardware APB master that sits directly upstream of the GRLIB `spictrl` APB slave port. It programs the SPI controller's mode register and streams words into the controller's transmit register from a valid/ready source. It returns each received word on a valid/ready sink. It replaces the software or bench sequence of a mode write, then a transmit write, then polling, then a receive read, with one word in flight at a time.

## Interface
Parameters:
- `PADDR_BASE`, default 32'h0000_0000: APB base address of the `spictrl` instance.
- `POLL_LIMIT`, default 1024: maximum event-register reads per wait phase before timeout, range 1..65535.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_mode` in 32: value written to the mode register (offset 0x20).
- `cfg_valid` in 1: request to configure. Sampled only in IDLE.
- `cfg_done` out 1: one-cycle pulse when the mode write completes.
- `tx_data` in 32, `tx_valid` in 1, `tx_ready` out 1: word to transmit.
- `rx_data` out 32, `rx_valid` out 1, `rx_ready` in 1: received word.
- `err` out 1: sticky error flag, cleared only by `rst`.
- `apb_psel` out 1, `apb_penable` out 1, `apb_pwrite` out 1, `apb_paddr` out 32, `apb_pwdata` out 32: APB master outputs.
- `apb_prdata` in 32, `apb_pready` in 1, `apb_pslverr` in 1: APB master inputs.

## Operation
Register offsets are added to `PADDR_BASE`: 0x20 mode, 0x24 event, 0x30 transmit, 0x34 receive. In the event register, bit 8 is NF (transmit not full) and bit 9 is NE (receive not empty).

States:
- **IDLE**: waits for `cfg_valid`. `tx_valid` is ignored.
- **CFG**: writes `cfg_mode` to 0x20. Then pulses `cfg_done` and goes to RUN.
- **RUN**: if `tx_valid`=1, goes to WAIT_NF. A `cfg_valid` in RUN is ignored; reconfiguration requires `rst`.
- **WAIT_NF**: reads 0x24. If NF=1, goes to TX; otherwise reads again.
- **TX**: writes `tx_data` to 0x30. `tx_ready` is high for exactly the cycle the ACCESS phase completes, which is when the word is consumed. Then goes to WAIT_NE.
- **WAIT_NE**: reads 0x24. If NE=1, goes to RX; otherwise reads again.
- **RX**: reads 0x34 and captures `apb_prdata` into `rx_data`. Then goes to HOLD.
- **HOLD**: `rx_valid`=1 and `rx_data` is stable until `rx_valid && rx_ready`. Then goes to RUN.

Poll counter (16 bits):
- Cleared on entry to WAIT_NF and WAIT_NE.
- Increments on each completed event read.
- When it reaches `POLL_LIMIT` without the awaited bit set: set `err`. From WAIT_NF, go to RUN without consuming the word, so `tx_ready` is never asserted. From WAIT_NE, go to RUN with no `rx_valid`.

Bus errors:
- `apb_pslverr`=1 at any completing ACCESS sets `err`. The FSM then proceeds as if the transfer succeeded.
- A completed receive read always produces an `rx_valid`, even if `err` is set.

Reset:
- A `rst` mid-transfer aborts the APB cycle immediately: `apb_psel` and `apb_penable` are 0 in the next cycle.
- A word whose `tx_ready` was not yet given is not consumed.

## Timing
- APB transfers:
  - SETUP cycle: `apb_psel`=1, `apb_penable`=0.
  - ACCESS cycles: `apb_psel`=1, `apb_penable`=1, held until `apb_pready`=1.
  - One idle cycle (`apb_psel`=0) follows every transfer.
  - `apb_paddr`, `apb_pwrite` and `apb_pwdata` are registered and stable from SETUP through the end of ACCESS.
- Reset values: all outputs 0, `apb_paddr`=0, `rx_data`=0, state IDLE, `err`=0.
- Latency with `apb_pready` tied to 1:
  - `cfg_valid` sampled at edge k: SETUP in cycle k+1, ACCESS in cycle k+2, `cfg_done` in cycle k+3.
  - Each transfer costs 3 cycles: SETUP, ACCESS, idle.
  - Minimum word round trip from `tx_valid` to `rx_valid`: 4 transfers, i.e. 12 cycles plus the SPI shift time observed through polls.
- `cfg_done` and `tx_ready` are single-cycle pulses.
- `rx_valid` is level-held in HOLD.
- `err` is set in the cycle after the offending ACCESS completes, or after the poll counter reaches `POLL_LIMIT`.

## Test plan
- **Configure, mode 0 at 1 Mbit/s**: `cfg_mode`=0x030B_0000, `PADDR_BASE`=0 -> one APB write, `apb_paddr`=0x20, `apb_pwdata`=0x030B_0000. `cfg_done` pulses 3 cycles after `cfg_valid`.
- **Single transfer, looped to a slave model**: `tx_data`=0x0012_3456 -> write to 0x30 with that data. Event polls run until NE. Read at 0x34 returns the slave word 0x0000_ABCD, so `rx_data`=0x0000_ABCD and `rx_valid`=1.
- **Backpressure**: `rx_ready`=0 for 20 cycles -> `rx_valid` stays 1 and `rx_data` is unchanged. No new APB transfer occurs even with `tx_valid`=1. Release `rx_ready` -> one handshake, then the FSM returns to RUN.
- **Wait states**: `apb_pready` low for 3 cycles on every access -> address and data are stable throughout. No duplicate `tx_ready`. 8 random words are all returned in order.
- **Timeout**: `POLL_LIMIT`=4, NE never set -> exactly 4 event reads at 0x24, then `err`=1, no `rx_valid`, FSM back in RUN.
- **Reset and slave error**: `rst` asserted during a transmit ACCESS -> `apb_psel`=0 in the next cycle, `tx_ready` is never pulsed, `err`=0. Separately, `apb_pslverr`=1 on a receive read -> `err`=1 and `rx_valid` is still presented.
